// File: rtl/nebula_pkg.sv
// Shared types and defaults for the Nebula link receive endpoint.
package nebula_pkg;

  localparam int NEBULA_FLIT_W = 64;
  localparam int NEBULA_NUM_VC = 4;
  localparam int NEBULA_VC_LSB = 0;
  localparam int CREDIT_VC_W   = 8;

  typedef logic [NEBULA_FLIT_W-1:0]         flit_t;
  typedef logic [$clog2(NEBULA_NUM_VC)-1:0] vc_id_t;

  typedef enum logic {
    RX_INIT,
    RX_RUN
  } rx_state_e;

endpackage

// File: rtl/nebula_vc_fifo.sv
// Per-VC synchronous FIFO. The head entry is read combinationally so the arbiter
// can offer it in the same cycle it becomes visible.
module nebula_vc_fifo #(
  parameter int FLIT_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_data,
  input  logic              pop,
  output logic [FLIT_W-1:0] head_data,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign head_data = mem[rd_ptr_q];
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/nebula_link_rx.sv
// Nebula credit-based link receiver: per-VC buffering, round-robin output with
// grant lock, one credit per dequeue, and an initial credit advertisement.
module nebula_link_rx
  import nebula_pkg::*;
#(
  parameter int FLIT_W = NEBULA_FLIT_W,
  parameter int NUM_VC = NEBULA_NUM_VC,
  parameter int VC_W   = $clog2(NUM_VC),
  parameter int VC_LSB = NEBULA_VC_LSB,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [FLIT_W-1:0]      rx_flit,
  output logic                   rx_ready,
  output logic                   credit_tx_valid,
  output logic [CREDIT_VC_W-1:0] credit_tx_vc,
  output logic                   out_valid,
  output logic [FLIT_W-1:0]      out_flit,
  output logic [VC_W-1:0]        out_vc,
  input  logic                   out_ready,
  output logic                   ovf_err,
  output logic [VC_W-1:0]        ovf_vc
);
  localparam int CTR_W     = $clog2(NUM_VC * DEPTH);
  localparam int DEPTH_LOG = $clog2(DEPTH);

  rx_state_e              state_q, state_d;
  logic [CTR_W-1:0]       init_ctr_q, init_ctr_d;
  logic                   rx_ready_q, rx_ready_d;
  logic                   credit_valid_q, credit_valid_d;
  logic [CREDIT_VC_W-1:0] credit_vc_q, credit_vc_d;
  logic [VC_W-1:0]        rr_q, rr_d;
  logic                   lock_q, lock_d;
  logic [VC_W-1:0]        lock_vc_q, lock_vc_d;
  logic                   ovf_err_q, ovf_err_d;
  logic [VC_W-1:0]        ovf_vc_q, ovf_vc_d;

  logic [NUM_VC-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FLIT_W-1:0] fifo_head [NUM_VC];

  logic [VC_W-1:0] wr_vc, grant, cand;
  logic            wr_en, pop, drop, any_valid;

  assign wr_vc     = rx_flit[VC_LSB +: VC_W];
  assign wr_en     = rx_valid && rx_ready_q;
  assign any_valid = |(~fifo_empty);
  assign pop       = any_valid && out_ready;
  // A full VC may still accept when its head leaves in the same cycle.
  assign drop      = wr_en && fifo_full[wr_vc] && !(pop && (grant == wr_vc));

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    assign fifo_push[gi] = wr_en && !drop && (wr_vc == VC_W'(gi));
    assign fifo_pop[gi]  = pop && (grant == VC_W'(gi));

    nebula_vc_fifo #(
      .FLIT_W(FLIT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push[gi]),
      .push_data(rx_flit),
      .pop      (fifo_pop[gi]),
      .head_data(fifo_head[gi]),
      .full     (fifo_full[gi]),
      .empty    (fifo_empty[gi])
    );
  end

  // Scan downward so the nonempty VC closest to the pointer wins.
  always_comb begin
    grant = rr_q;
    cand  = rr_q;
    if (lock_q) begin
      grant = lock_vc_q;
    end else begin
      for (int i = NUM_VC - 1; i >= 0; i--) begin
        cand = rr_q + VC_W'(i);
        if (!fifo_empty[cand]) grant = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    init_ctr_d     = init_ctr_q;
    rx_ready_d     = (state_q == RX_RUN);
    credit_valid_d = 1'b0;
    credit_vc_d    = '0;
    rr_d           = rr_q;
    lock_d         = lock_q;
    lock_vc_d      = lock_vc_q;
    ovf_err_d      = ovf_err_q;
    ovf_vc_d       = ovf_vc_q;

    case (state_q)
      RX_INIT: begin
        credit_valid_d = 1'b1;
        credit_vc_d    = CREDIT_VC_W'(init_ctr_q >> DEPTH_LOG);
        init_ctr_d     = init_ctr_q + 1'b1;
        if (init_ctr_q == CTR_W'(NUM_VC * DEPTH - 1)) state_d = RX_RUN;
      end
      default: begin
        credit_valid_d = pop;
        credit_vc_d    = pop ? CREDIT_VC_W'(grant) : '0;
      end
    endcase

    if (pop) begin
      lock_d = 1'b0;
      rr_d   = grant + 1'b1;
    end else if (any_valid) begin
      lock_d    = 1'b1;
      lock_vc_d = grant;
    end

    if (drop && !ovf_err_q) begin
      ovf_err_d = 1'b1;
      ovf_vc_d  = wr_vc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RX_INIT;
      init_ctr_q     <= '0;
      rx_ready_q     <= 1'b0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      rr_q           <= '0;
      lock_q         <= 1'b0;
      lock_vc_q      <= '0;
      ovf_err_q      <= 1'b0;
      ovf_vc_q       <= '0;
    end else begin
      state_q        <= state_d;
      init_ctr_q     <= init_ctr_d;
      rx_ready_q     <= rx_ready_d;
      credit_valid_q <= credit_valid_d;
      credit_vc_q    <= credit_vc_d;
      rr_q           <= rr_d;
      lock_q         <= lock_d;
      lock_vc_q      <= lock_vc_d;
      ovf_err_q      <= ovf_err_d;
      ovf_vc_q       <= ovf_vc_d;
    end
  end

  assign rx_ready        = rx_ready_q;
  assign credit_tx_valid = credit_valid_q;
  assign credit_tx_vc    = credit_vc_q;
  assign out_valid       = any_valid;
  assign out_flit        = any_valid ? fifo_head[grant] : '0;
  assign out_vc          = any_valid ? grant : '0;
  assign ovf_err         = ovf_err_q;
  assign ovf_vc          = ovf_vc_q;

endmodule

// File: tb/tb_nebula_link_rx.sv
// Directed bench for nebula_link_rx with NUM_VC=4, DEPTH=4.
module tb_nebula_link_rx;
  import nebula_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [63:0] rx_flit = '0;
  logic        out_ready = 1'b0;
  logic        rx_ready;
  logic        credit_tx_valid;
  logic [7:0]  credit_tx_vc;
  logic        out_valid;
  logic [63:0] out_flit;
  logic [1:0]  out_vc;
  logic        ovf_err;
  logic [1:0]  ovf_vc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nebula_link_rx #(
    .FLIT_W(64),
    .NUM_VC(4),
    .VC_W  (2),
    .VC_LSB(0),
    .DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_valid       (rx_valid),
    .rx_flit        (rx_flit),
    .rx_ready       (rx_ready),
    .credit_tx_valid(credit_tx_valid),
    .credit_tx_vc   (credit_tx_vc),
    .out_valid      (out_valid),
    .out_flit       (out_flit),
    .out_vc         (out_vc),
    .out_ready      (out_ready),
    .ovf_err        (ovf_err),
    .ovf_vc         (ovf_vc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one flit for one clock edge.
  task automatic put(input flit_t f);
    rx_valid = 1'b1;
    rx_flit  = f;
    tick();
    rx_valid = 1'b0;
    $display("[%0t] rx vc=%0d flit=%h", $time, f[1:0], f);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rx_ready"},  rx_ready, 0);
    chk({tag, "_credit_v"},  credit_tx_valid, 0);
    chk({tag, "_credit_vc"}, credit_tx_vc, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_flit"},  out_flit, 0);
    chk({tag, "_out_vc"},    out_vc, 0);
    chk({tag, "_ovf_err"},   ovf_err, 0);
    chk({tag, "_ovf_vc"},    ovf_vc, 0);
  endtask

  // Called right after rst drops: 16 init credits, then rx_ready rises.
  task automatic init_seq(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("%s_init_v%0d", tag, k), credit_tx_valid, 1);
      chk($sformatf("%s_init_vc%0d", tag, k), credit_tx_vc, (k - 1) / 4);
      chk($sformatf("%s_init_rdy%0d", tag, k), rx_ready, 0);
      chk($sformatf("%s_init_ov%0d", tag, k), out_valid, 0);
      $display("[%0t] %s credit vc=%0d", $time, tag, credit_tx_vc);
    end
    tick();
    chk({tag, "_run_rdy"}, rx_ready, 1);
    chk({tag, "_run_cv"},  credit_tx_valid, 0);
    chk({tag, "_run_ov"},  out_valid, 0);
  endtask

  function automatic flit_t mk(input logic [15:0] tag, input int idx, input int vc);
    flit_t f;
    f = {tag, 48'h0};
    f[15:8] = idx[7:0];
    f[1:0]  = vc[1:0];
    return f;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset and credit advertisement
    tick();
    tick();
    check_reset("t1_rst");
    rst = 1'b0;
    init_seq("t1");

    // 2: back-to-back VC2 then VC0 with out_ready high
    out_ready = 1'b1;
    put(mk(16'h2222, 0, 2));
    chk("t2_ov_a", out_valid, 1);
    chk("t2_vc_a", out_vc, 2);
    chk("t2_fl_a", out_flit, mk(16'h2222, 0, 2));
    chk("t2_cv_a", credit_tx_valid, 0);
    put(mk(16'h2020, 1, 0));
    chk("t2_vc_b", out_vc, 0);
    chk("t2_fl_b", out_flit, mk(16'h2020, 1, 0));
    chk("t2_cv_b", credit_tx_valid, 1);
    chk("t2_cvc_b", credit_tx_vc, 2);
    tick();
    chk("t2_ov_c", out_valid, 0);
    chk("t2_cv_c", credit_tx_valid, 1);
    chk("t2_cvc_c", credit_tx_vc, 0);
    tick();
    chk("t2_cv_d", credit_tx_valid, 0);

    // 3: fill VC1 with back-pressure, head held, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(mk(16'hAAAA, i, 1));
      chk($sformatf("t3_hold%0d", i), out_flit, mk(16'hAAAA, 0, 1));
      chk($sformatf("t3_hvc%0d", i), out_vc, 1);
    end
    chk("t3_ovf", ovf_err, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_fl%0d", i), out_flit, mk(16'hAAAA, i, 1));
      tick();
      chk($sformatf("t3_cv%0d", i), credit_tx_valid, 1);
      chk($sformatf("t3_cvc%0d", i), credit_tx_vc, 1);
    end
    chk("t3_empty", out_valid, 0);
    chk("t3_ovf_end", ovf_err, 0);

    // 4: two flits per VC, round-robin drain 0,1,2,3,0,1,2,3
    out_ready = 1'b0;
    for (int j = 0; j < 8; j++) put(mk(16'hC4C4, j, j % 4));
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t4_vc%0d", k), out_vc, k % 4);
      chk($sformatf("t4_fl%0d", k), out_flit, mk(16'hC4C4, k, k % 4));
      tick();
      chk($sformatf("t4_cvc%0d", k), credit_tx_vc, k % 4);
    end
    chk("t4_empty", out_valid, 0);

    // 5: overflow on VC3 is sticky; later VC1 overflow keeps ovf_vc=3
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(mk(16'hD5D5, i, 3));
    chk("t5_no_ovf", ovf_err, 0);
    put(mk(16'hDEAD, 9, 3));
    chk("t5_ovf", ovf_err, 1);
    chk("t5_ovf_vc", ovf_vc, 3);
    for (int i = 0; i < 5; i++) put(mk(16'hD5D5, i, 1));
    chk("t5_ovf2", ovf_err, 1);
    chk("t5_ovf_vc2", ovf_vc, 3);
    // Write into full VC3 while its head is dequeued: must be kept.
    out_ready = 1'b1;
    chk("t5_head_vc", out_vc, 3);
    chk("t5_head_fl", out_flit, mk(16'hD5D5, 0, 3));
    put(mk(16'hD5D5, 4, 3));
    for (int n = 0; n < 8; n++) begin
      int vc;
      int idx;
      vc  = (n % 2 == 0) ? 1 : 3;
      idx = n / 2 + ((vc == 3) ? 1 : 0);
      chk($sformatf("t5_vc%0d", n), out_vc, vc);
      chk($sformatf("t5_fl%0d", n), out_flit, mk(16'hD5D5, idx, vc));
      tick();
    end
    chk("t5_empty", out_valid, 0);

    // 6: reset with flits buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) put(mk(16'h6666, i, 2));
    chk("t6_pre_ov", out_valid, 1);
    chk("t6_pre_fl", out_flit, mk(16'h6666, 0, 2));
    #2;
    rst = 1'b1;
    #1;
    check_reset("t6_rst");
    tick();
    tick();
    rst = 1'b0;
    init_seq("t6");
    chk("t6_no_stale", out_flit, 0);
    out_ready = 1'b1;
    put(mk(16'h7777, 5, 2));
    chk("t6_new_ov", out_valid, 1);
    chk("t6_new_fl", out_flit, mk(16'h7777, 5, 2));
    tick();
    chk("t6_new_cvc", credit_tx_vc, 2);
    chk("t6_final_ov", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
